// File: rtl/crosswalk_scheduler_if.sv
// Crosswalk scheduler bus: button inputs, sequencer handshake and lamp/status outputs.
interface crosswalk_scheduler_if #(
  parameter int N_REQ = 2
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] btn;
  logic             seq_busy;
  logic [N_REQ-1:0] start;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] wait_lamp;
  logic             active;
  logic             fault;

  modport master (
    output btn, seq_busy,
    input  start, grant_idx, wait_lamp, active, fault
  );

  modport slave (
    input  btn, seq_busy,
    output start, grant_idx, wait_lamp, active, fault
  );
endinterface

// File: rtl/crosswalk_scheduler.sv
// Round-robin crossing scheduler: debounced button latching, road-green guard timer,
// and a GRANT/ACK/RUN handshake with the shared crossing sequencer.
module crosswalk_scheduler #(
  parameter int N_REQ       = 2,
  parameter int MIN_GREEN   = 1000,
  parameter int DEBOUNCE    = 3,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  crosswalk_scheduler_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW    = $clog2(MIN_GREEN + 1);
  localparam int DW    = $clog2(DEBOUNCE + 1);
  localparam int AW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [GW-1:0] GREEN_MAX = GW'(MIN_GREEN);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_sync1, r_sync2, r_acc;
  logic [DW-1:0]    r_db_cnt [N_REQ];
  logic [N_REQ-1:0] r_pending, w_pend_nxt;
  logic [GW-1:0]    r_green;
  logic [AW-1:0]    r_ack_cnt;
  logic [IDX_W-1:0] r_grant_idx, r_last_grant, w_winner;
  logic             r_fault, w_ack_timeout, w_serving;
  logic [N_REQ-1:0] w_start;
  int               w_best, w_dist;

  // r_acc pulses once per press: only on the cycle the counter steps into saturation
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      for (int i = 0; i < N_REQ; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_REQ; i++) begin
        r_acc[i] <= r_sync2[i] && (r_db_cnt[i] == DB_LAST);
        if (!r_sync2[i])
          r_db_cnt[i] <= '0;
        else if (r_db_cnt[i] != DB_MAX)
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end

  assign w_serving = (r_state == S_ACK) || (r_state == S_RUN);

  always_comb begin
    w_pend_nxt = r_pending;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_acc[i] && !(w_serving && (r_grant_idx == IDX_W'(i))))
        w_pend_nxt[i] = 1'b1;
    end
    // A press landing on the granted index in GRANT is dropped, not re-queued
    if (r_state == S_GRANT)
      w_pend_nxt[r_grant_idx] = 1'b0;
  end

  // Winner is the pending index at the smallest rotational distance past last_grant
  always_comb begin
    w_winner = r_last_grant;
    w_best   = N_REQ;
    w_dist   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = j - int'(r_last_grant) - 1;
      if (w_dist < 0) w_dist = w_dist + N_REQ;
      if (r_pending[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:  if ((|r_pending) && (r_green == GREEN_MAX)) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_ACK;
      S_ACK: begin
        if (bus.seq_busy) begin
          w_state_nxt = S_RUN;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_state_nxt   = S_IDLE;
          w_ack_timeout = 1'b1;
        end
      end
      S_RUN:   if (!bus.seq_busy) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_green      <= '0;
      r_ack_cnt    <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_fault      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT))
        r_grant_idx <= w_winner;
      if (r_state == S_GRANT)
        r_last_grant <= r_grant_idx;
      // A timed-out handshake leaves the guard intact; only a real crossing restarts it
      if ((r_state == S_RUN) && (w_state_nxt == S_IDLE))
        r_green <= '0;
      else if ((r_state == S_IDLE) && (r_green != GREEN_MAX))
        r_green <= r_green + 1'b1;
      r_ack_cnt <= (r_state == S_ACK) ? r_ack_cnt + 1'b1 : '0;
      if (w_ack_timeout)
        r_fault <= 1'b1;
    end
  end

  always_comb begin
    w_start = '0;
    if (r_state == S_GRANT)
      w_start[r_grant_idx] = 1'b1;
  end

  assign bus.start     = w_start;
  assign bus.grant_idx = r_grant_idx;
  assign bus.wait_lamp = r_pending;
  assign bus.active    = w_serving;
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_crosswalk_scheduler.sv
// Directed bench for crosswalk_scheduler with a cycle-level behavioural model checked every cycle.
module tb_crosswalk_scheduler;
  localparam int N  = 2;
  localparam int MG = 10;
  localparam int DB = 3;
  localparam int AT = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_GRANT = 1;
  localparam int PH_ACK   = 2;
  localparam int PH_RUN   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crosswalk_scheduler_if #(.N_REQ(N)) bus();

  crosswalk_scheduler #(
    .N_REQ(N), .MIN_GREEN(MG), .DEBOUNCE(DB), .ACK_TIMEOUT(AT)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_pulses = 0;
  int p0 = 0;
  int resp_cnt = 0;
  int resp_len = 20;
  bit resp_on = 1'b0;

  // Model state: raw press run lengths, a 3-edge accept delay, and a crossing phase
  int         m_cyc = 0;
  int         m_phase = PH_IDLE;
  int         m_green = 0;
  int         m_gidx = 0;
  int         m_last = N - 1;
  int         m_ack_entry = 0;
  int         m_run [N];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_p0 = '0, m_p1 = '0, m_p2 = '0;
  bit         m_fault = 1'b0;
  bit         m_valid = 1'b0;

  function automatic int pick(input logic [N-1:0] p, input int last);
    int w;
    int j;
    bit f;
    w = 0;
    f = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (!f && p[j]) begin
        f = 1'b1;
        w = j;
      end
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    logic [N-1:0] trig, apply, blk, nxt;
    m_cyc++;
    if (rst) begin
      m_phase = PH_IDLE; m_green = 0; m_gidx = 0; m_last = N - 1;
      m_pend = '0; m_p0 = '0; m_p1 = '0; m_p2 = '0; m_fault = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_valid = 1'b1;
    end else begin
      trig = '0;
      for (int i = 0; i < N; i++) begin
        if (bus.btn[i]) begin
          if (m_run[i] < 1000) m_run[i]++;
        end else begin
          m_run[i] = 0;
        end
        trig[i] = (m_run[i] == DB);
      end
      apply = m_p2; m_p2 = m_p1; m_p1 = m_p0; m_p0 = trig;
      blk = '0;
      if (m_phase == PH_ACK || m_phase == PH_RUN) blk = N'(1) << m_gidx;
      nxt = m_pend | (apply & ~blk);
      if (m_phase == PH_GRANT) nxt = nxt & ~(N'(1) << m_gidx);
      case (m_phase)
        PH_IDLE: begin
          if (m_pend != '0 && m_green >= MG) begin
            m_gidx  = pick(m_pend, m_last);
            m_phase = PH_GRANT;
          end
          if (m_green < MG) m_green++;
        end
        PH_GRANT: begin
          m_last = m_gidx;
          m_phase = PH_ACK;
          m_ack_entry = m_cyc;
        end
        PH_ACK: begin
          if (bus.seq_busy) m_phase = PH_RUN;
          else if (m_cyc - m_ack_entry >= AT) begin
            m_fault = 1'b1;
            m_phase = PH_IDLE;
          end
        end
        default: begin
          if (!bus.seq_busy) begin
            m_phase = PH_IDLE;
            m_green = 0;
          end
        end
      endcase
      m_pend = nxt;
    end
  endtask

  task automatic compare();
    logic [N-1:0] es;
    if (bus.start != '0) n_pulses++;
    if (m_valid) begin
      es = '0;
      if (m_phase == PH_GRANT) es = N'(1) << m_gidx;
      chk("start", 32'(bus.start), 32'(es));
      chk("grant_idx", 32'(bus.grant_idx), 32'(m_gidx));
      chk("wait_lamp", 32'(bus.wait_lamp), 32'(m_pend));
      chk("active", 32'(bus.active), (m_phase == PH_ACK || m_phase == PH_RUN) ? 32'd1 : 32'd0);
      chk("fault", 32'(bus.fault), 32'(m_fault));
    end
  endtask

  // One clock: model samples inputs at the edge, outputs are checked and inputs driven at negedge
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) bus.seq_busy = 1'b0;
    end else if (resp_on && bus.start != '0) begin
      bus.seq_busy = 1'b1;
      resp_cnt = resp_len;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn = '0;
    bus.seq_busy = 1'b0;
    resp_cnt = 0;
    step();
    step();
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_wait", 32'(bus.wait_lamp), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_gidx", 32'(bus.grant_idx), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    bus.btn = '0;
    bus.seq_busy = 1'b0;

    // Single press, guard from reset, normal crossing
    resp_on = 1'b1; resp_len = 20;
    do_reset();
    p0 = n_pulses;
    bus.btn = 2'b01;
    repeat (5) step();
    chk("t1_wait_e5", 32'(bus.wait_lamp), 32'd0);
    step();
    chk("t1_wait_e6", 32'(bus.wait_lamp), 32'd1);
    repeat (4) step();
    chk("t1_start_e10", 32'(bus.start), 32'd0);
    step();
    chk("t1_start_e11", 32'(bus.start), 32'd1);
    chk("t1_gidx_e11", 32'(bus.grant_idx), 32'd0);
    step();
    chk("t1_start_e12", 32'(bus.start), 32'd0);
    chk("t1_active_e12", 32'(bus.active), 32'd1);
    bus.btn = '0;
    repeat (25) step();
    chk("t1_active_end", 32'(bus.active), 32'd0);
    chk("t1_pulses", 32'(n_pulses - p0), 32'd1);

    // Glitch shorter than the debounce window
    do_reset();
    p0 = n_pulses;
    bus.btn = 2'b01;
    step(); step();
    bus.btn = '0;
    repeat (30) step();
    chk("t2_wait", 32'(bus.wait_lamp), 32'd0);
    chk("t2_pulses", 32'(n_pulses - p0), 32'd0);

    // Simultaneous presses served round-robin with guard between crossings
    do_reset();
    p0 = n_pulses;
    bus.btn = 2'b11;
    repeat (11) step();
    chk("t3_start0", 32'(bus.start), 32'd1);
    chk("t3_gidx0", 32'(bus.grant_idx), 32'd0);
    bus.btn = '0;
    repeat (31) step();
    chk("t3_start_e42", 32'(bus.start), 32'd0);
    chk("t3_wait_e42", 32'(bus.wait_lamp), 32'd2);
    chk("t3_active_e42", 32'(bus.active), 32'd0);
    step();
    chk("t3_start1", 32'(bus.start), 32'd2);
    chk("t3_gidx1", 32'(bus.grant_idx), 32'd1);
    repeat (35) step();
    chk("t3_active_end", 32'(bus.active), 32'd0);
    chk("t3_pulses", 32'(n_pulses - p0), 32'd2);

    // Sequencer never acknowledges
    resp_on = 1'b0;
    do_reset();
    p0 = n_pulses;
    bus.btn = 2'b01;
    repeat (12) step();
    chk("t4_active_ack", 32'(bus.active), 32'd1);
    bus.btn = '0;
    repeat (3) step();
    chk("t4_fault_e15", 32'(bus.fault), 32'd0);
    chk("t4_active_e15", 32'(bus.active), 32'd1);
    step();
    chk("t4_fault_e16", 32'(bus.fault), 32'd1);
    chk("t4_active_e16", 32'(bus.active), 32'd0);
    chk("t4_wait_e16", 32'(bus.wait_lamp), 32'd0);
    repeat (20) step();
    chk("t4_fault_hold", 32'(bus.fault), 32'd1);
    chk("t4_pulses", 32'(n_pulses - p0), 32'd1);

    // Presses during RUN: other index queued, granted index ignored
    resp_on = 1'b1;
    do_reset();
    p0 = n_pulses;
    bus.btn = 2'b01;
    repeat (12) step();
    bus.btn = '0;
    step();
    chk("t5_active_run", 32'(bus.active), 32'd1);
    bus.btn = 2'b11;
    repeat (6) step();
    chk("t5_wait_run", 32'(bus.wait_lamp), 32'd2);
    chk("t5_active_e19", 32'(bus.active), 32'd1);
    bus.btn = '0;
    repeat (23) step();
    chk("t5_start_e42", 32'(bus.start), 32'd0);
    step();
    chk("t5_start1", 32'(bus.start), 32'd2);
    chk("t5_gidx1", 32'(bus.grant_idx), 32'd1);
    step();
    chk("t5_wait_e44", 32'(bus.wait_lamp), 32'd0);
    repeat (40) step();
    chk("t5_pulses", 32'(n_pulses - p0), 32'd2);
    chk("t5_wait_end", 32'(bus.wait_lamp), 32'd0);

    // Reset in the middle of a crossing with another request queued
    do_reset();
    bus.btn = 2'b11;
    repeat (11) step();
    bus.btn = '0;
    repeat (4) step();
    chk("t6_active_run", 32'(bus.active), 32'd1);
    chk("t6_wait_run", 32'(bus.wait_lamp), 32'd2);
    p0 = n_pulses;
    rst = 1'b1;
    resp_on = 1'b0;
    step();
    chk("t6_start_rst", 32'(bus.start), 32'd0);
    chk("t6_wait_rst", 32'(bus.wait_lamp), 32'd0);
    chk("t6_active_rst", 32'(bus.active), 32'd0);
    chk("t6_fault_rst", 32'(bus.fault), 32'd0);
    chk("t6_gidx_rst", 32'(bus.grant_idx), 32'd0);
    rst = 1'b0;
    repeat (40) step();
    chk("t6_pulses", 32'(n_pulses - p0), 32'd0);
    chk("t6_wait_end", 32'(bus.wait_lamp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
